scr1_tcm_dmem_arb: RTL and testbench

Two-requester arbiter that shares the single data port of the tightly-coupled memory between the core data interface and a DMA/loader master. It sits between the core dmem router, the DMA engine and the TCM data port, and carries the SCR1 memory request/response protocol on all three sides. It grants one request per cycle, range-checks DMA addresses, and routes the one-cycle-delayed TCM response back to the requester that owns it.

---
 rtl/scr1_tcm_dmem_arb.sv | 185 ++++++++++++++++++
 tb/tb_scr1_tcm_dmem_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tcm_dmem_arb.sv
// Two-requester arbiter sharing the TCM data port between core dmem and a DMA/loader master.
// Define SCR1_TCM_ARB_STARVE_EN to enable the DMA anti-starvation counter (STARVE_LIMIT).
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 64
`endif
`ifndef SCR1_IMEM_AWIDTH
`define SCR1_IMEM_AWIDTH 32
`endif

package scr1_tcm_dmem_arb_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_tcm_dmem_arb
    import scr1_tcm_dmem_arb_pkg::*;
#(
    parameter logic [`SCR1_IMEM_AWIDTH-1:0] SCR1_TCM_SIZE = `SCR1_IMEM_AWIDTH'h00010000,
    parameter int unsigned                  STARVE_LIMIT  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // Core side
    input  logic                         core_req_i,
    input  type_scr1_mem_cmd_e           core_cmd_i,
    input  type_scr1_mem_width_e         core_width_i,
    input  logic [`SCR1_DMEM_AWIDTH-1:0] core_addr_i,
    input  logic [`SCR1_DMEM_DWIDTH-1:0] core_wdata_i,
    output logic                         core_req_ack_o,
    output logic [`SCR1_DMEM_DWIDTH-1:0] core_rdata_o,
    output type_scr1_mem_resp_e          core_resp_o,
    // DMA side
    input  logic                         dma_req_i,
    input  type_scr1_mem_cmd_e           dma_cmd_i,
    input  type_scr1_mem_width_e         dma_width_i,
    input  logic [`SCR1_DMEM_AWIDTH-1:0] dma_addr_i,
    input  logic [`SCR1_DMEM_DWIDTH-1:0] dma_wdata_i,
    output logic                         dma_req_ack_o,
    output logic [`SCR1_DMEM_DWIDTH-1:0] dma_rdata_o,
    output type_scr1_mem_resp_e          dma_resp_o,
    // TCM side
    output logic                         tcm_req_o,
    output type_scr1_mem_cmd_e           tcm_cmd_o,
    output type_scr1_mem_width_e         tcm_width_o,
    output logic [`SCR1_DMEM_AWIDTH-1:0] tcm_addr_o,
    output logic [`SCR1_DMEM_DWIDTH-1:0] tcm_wdata_o,
    input  logic                         tcm_req_ack_i,
    input  logic [`SCR1_DMEM_DWIDTH-1:0] tcm_rdata_i,
    input  type_scr1_mem_resp_e          tcm_resp_i
);

    localparam int unsigned TcmAw = $clog2(SCR1_TCM_SIZE);

    typedef enum logic [1:0] {
        OwnNone   = 2'd0,
        OwnCore   = 2'd1,
        OwnDma    = 2'd2,
        OwnDmaErr = 2'd3
    } rsp_own_e;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    rsp_own_e rsp_own_q, rsp_own_d;
    logic     starved;
    logic     core_gnt;
    logic     dma_gnt;
    logic     dma_oor;
    logic     dma_fwd;

    assign dma_oor  = |(dma_addr_i >> TcmAw);
    // Requests are masked while in reset so nothing is forwarded or acked.
    assign dma_gnt  = rst_n & dma_req_i & (~core_req_i | starved);
    assign core_gnt = rst_n & core_req_i & ~dma_gnt;
    assign dma_fwd  = dma_gnt & ~dma_oor;

    assign core_req_ack_o = core_gnt & tcm_req_ack_i;
    assign dma_req_ack_o  = dma_gnt & (dma_oor | tcm_req_ack_i);

`ifdef SCR1_TCM_ARB_STARVE_EN
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

    assign starved = (starve_cnt_q == CntW'(STARVE_LIMIT));

    // A starved but un-acked DMA holds the counter at the limit, so it keeps winning.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!dma_req_i || dma_req_ack_o) begin
            starve_cnt_d = '0;
        end else if (!dma_gnt && !starved) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starved = 1'b0;
`endif

    always_comb begin
        tcm_req_o   = 1'b0;
        tcm_cmd_o   = SCR1_MEM_CMD_RD;
        tcm_width_o = SCR1_MEM_WIDTH_BYTE;
        tcm_addr_o  = '0;
        tcm_wdata_o = '0;
        if (core_gnt) begin
            tcm_req_o   = 1'b1;
            tcm_cmd_o   = core_cmd_i;
            tcm_width_o = core_width_i;
            tcm_addr_o  = core_addr_i;
            tcm_wdata_o = core_wdata_i;
        end else if (dma_fwd) begin
            tcm_req_o   = 1'b1;
            tcm_cmd_o   = dma_cmd_i;
            tcm_width_o = dma_width_i;
            tcm_addr_o  = dma_addr_i;
            tcm_wdata_o = dma_wdata_i;
        end
    end

    always_comb begin
        rsp_own_d = OwnNone;
        if (core_req_ack_o) begin
            rsp_own_d = OwnCore;
        end else if (dma_req_ack_o) begin
            rsp_own_d = dma_oor ? OwnDmaErr : OwnDma;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_own_q <= OwnNone;
        end else begin
            rsp_own_q <= rsp_own_d;
        end
    end

    always_comb begin
        core_resp_o  = SCR1_MEM_RESP_NOTRDY;
        core_rdata_o = '0;
        dma_resp_o   = SCR1_MEM_RESP_NOTRDY;
        dma_rdata_o  = '0;
        case (rsp_own_q)
            OwnCore: begin
                core_resp_o  = tcm_resp_i;
                core_rdata_o = tcm_rdata_i;
            end
            OwnDma: begin
                dma_resp_o  = tcm_resp_i;
                dma_rdata_o = tcm_rdata_i;
            end
            OwnDmaErr: begin
                dma_resp_o = SCR1_MEM_RESP_RDY_ER;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_scr1_tcm_dmem_arb.sv
// Scoreboard bench for scr1_tcm_dmem_arb: directed cycles push expectations, a monitor compares.
module tb_scr1_tcm_dmem_arb;
    import scr1_tcm_dmem_arb_pkg::*;

`ifdef SCR1_TCM_ARB_STARVE_EN
    localparam bit StarveEn = 1'b1;
`else
    localparam bit StarveEn = 1'b0;
`endif

    localparam logic [1:0]  NR     = 2'b00;
    localparam logic [1:0]  OK     = 2'b01;
    localparam logic [1:0]  ER     = 2'b10;
    localparam logic        RD     = 1'b0;
    localparam logic        WR     = 1'b1;
    localparam logic [63:0] CoreWd = 64'hC0C0_0000_0000_0001;
    localparam logic [63:0] DmaWd  = 64'hD0D0_0000_0000_0002;

    typedef struct {
        int          cyc;
        logic        tcm_req;
        logic        core_ack;
        logic        dma_ack;
        logic        tcm_cmd;
        logic [1:0]  tcm_width;
        logic [31:0] tcm_addr;
        logic [63:0] tcm_wdata;
    } ack_exp_t;

    typedef struct {
        int          cyc;
        logic [1:0]  core_resp;
        logic [63:0] core_rdata;
        logic [1:0]  dma_resp;
        logic [63:0] dma_rdata;
    } rsp_exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 core_req, dma_req;
    type_scr1_mem_cmd_e   core_cmd, dma_cmd;
    type_scr1_mem_width_e core_width, dma_width;
    logic [31:0]          core_addr, dma_addr;
    logic [63:0]          core_wdata, dma_wdata;
    logic                 core_req_ack, dma_req_ack;
    logic [63:0]          core_rdata, dma_rdata;
    type_scr1_mem_resp_e  core_resp, dma_resp;
    logic                 tcm_req;
    type_scr1_mem_cmd_e   tcm_cmd;
    type_scr1_mem_width_e tcm_width;
    logic [31:0]          tcm_addr;
    logic [63:0]          tcm_wdata;
    logic                 tcm_req_ack;
    logic [63:0]          tcm_rdata = 64'h0;
    type_scr1_mem_resp_e  tcm_resp = SCR1_MEM_RESP_NOTRDY;
    logic [63:0]          rd_next;

    int       cyc = 0;
    int       checks = 0;
    int       failures = 0;
    ack_exp_t ack_q[$];
    rsp_exp_t rsp_q[$];

    scr1_tcm_dmem_arb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_req_i     (core_req),
        .core_cmd_i     (core_cmd),
        .core_width_i   (core_width),
        .core_addr_i    (core_addr),
        .core_wdata_i   (core_wdata),
        .core_req_ack_o (core_req_ack),
        .core_rdata_o   (core_rdata),
        .core_resp_o    (core_resp),
        .dma_req_i      (dma_req),
        .dma_cmd_i      (dma_cmd),
        .dma_width_i    (dma_width),
        .dma_addr_i     (dma_addr),
        .dma_wdata_i    (dma_wdata),
        .dma_req_ack_o  (dma_req_ack),
        .dma_rdata_o    (dma_rdata),
        .dma_resp_o     (dma_resp),
        .tcm_req_o      (tcm_req),
        .tcm_cmd_o      (tcm_cmd),
        .tcm_width_o    (tcm_width),
        .tcm_addr_o     (tcm_addr),
        .tcm_wdata_o    (tcm_wdata),
        .tcm_req_ack_i  (tcm_req_ack),
        .tcm_rdata_i    (tcm_rdata),
        .tcm_resp_i     (tcm_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // TCM model: OK one cycle after acceptance; rdata always driven so stray data is visible.
    always @(posedge clk) begin
        tcm_resp  <= (tcm_req && tcm_req_ack) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
        tcm_rdata <= rd_next;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        ack_exp_t a;
        rsp_exp_t r;
        if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
            a = ack_q.pop_front();
            chk("tcm_req", 64'(tcm_req), 64'(a.tcm_req));
            chk("core_req_ack", 64'(core_req_ack), 64'(a.core_ack));
            chk("dma_req_ack", 64'(dma_req_ack), 64'(a.dma_ack));
            chk("tcm_cmd", 64'(tcm_cmd), 64'(a.tcm_cmd));
            chk("tcm_width", 64'(tcm_width), 64'(a.tcm_width));
            chk("tcm_addr", 64'(tcm_addr), 64'(a.tcm_addr));
            chk("tcm_wdata", tcm_wdata, a.tcm_wdata);
        end
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
            r = rsp_q.pop_front();
            chk("core_resp", 64'(core_resp), 64'(r.core_resp));
            chk("core_rdata", core_rdata, r.core_rdata);
            chk("dma_resp", 64'(dma_resp), 64'(r.dma_resp));
            chk("dma_rdata", dma_rdata, r.dma_rdata);
        end
    end

    // One cycle of stimulus; ec*/ed* describe the responses expected in the following cycle.
    task automatic step(input logic rstn, input logic creq, input logic ccmd,
                        input logic [31:0] caddr, input logic dreq, input logic dcmd,
                        input logic [31:0] daddr, input logic tack, input logic [63:0] rd,
                        input logic etreq, input int win, input logic ecack, input logic edack,
                        input logic [1:0] ecr, input logic [63:0] ecd,
                        input logic [1:0] edr, input logic [63:0] edd);
        ack_exp_t a;
        rsp_exp_t r;
        rst_n       = rstn;
        core_req    = creq;
        core_cmd    = type_scr1_mem_cmd_e'(ccmd);
        core_addr   = caddr;
        dma_req     = dreq;
        dma_cmd     = type_scr1_mem_cmd_e'(dcmd);
        dma_addr    = daddr;
        tcm_req_ack = tack;
        rd_next     = rd;
        a.cyc       = cyc;
        a.tcm_req   = etreq;
        a.core_ack  = ecack;
        a.dma_ack   = edack;
        a.tcm_cmd   = !etreq ? 1'b0 : (win == 1 ? ccmd : dcmd);
        a.tcm_width = !etreq ? 2'b00 : (win == 1 ? 2'b10 : 2'b01);
        a.tcm_addr  = !etreq ? 32'h0 : (win == 1 ? caddr : daddr);
        a.tcm_wdata = !etreq ? 64'h0 : (win == 1 ? CoreWd : DmaWd);
        ack_q.push_back(a);
        r.cyc        = cyc + 1;
        r.core_resp  = ecr;
        r.core_rdata = ecd;
        r.dma_resp   = edr;
        r.dma_rdata  = edd;
        rsp_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [63:0] rd);
        step(1'b1, 1'b0, RD, 32'h0, 1'b0, RD, 32'h0, 1'b1, rd,
             1'b0, 0, 1'b0, 1'b0, NR, 64'h0, NR, 64'h0);
    endtask

    initial begin
        logic        dw;
        logic        tk;
        logic [63:0] rd;
        core_req    = 1'b0;
        dma_req     = 1'b0;
        core_cmd    = SCR1_MEM_CMD_RD;
        dma_cmd     = SCR1_MEM_CMD_RD;
        core_width  = SCR1_MEM_WIDTH_WORD;
        dma_width   = SCR1_MEM_WIDTH_HWORD;
        core_addr   = 32'h0;
        dma_addr    = 32'h0;
        core_wdata  = CoreWd;
        dma_wdata   = DmaWd;
        tcm_req_ack = 1'b0;
        rd_next     = 64'h0;
        @(posedge clk);
        #1;

        // Reset held with both requesting: nothing forwarded or acked.
        step(1'b0, 1'b1, RD, 32'h100, 1'b1, RD, 32'h200, 1'b1, 64'hAA,
             1'b0, 0, 1'b0, 1'b0, NR, 64'h0, NR, 64'h0);
        step(1'b0, 1'b1, RD, 32'h100, 1'b1, RD, 32'h200, 1'b1, 64'hAB,
             1'b0, 0, 1'b0, 1'b0, NR, 64'h0, NR, 64'h0);
        idle(64'h55);

        // Core-only read
        step(1'b1, 1'b1, RD, 32'h100, 1'b0, RD, 32'h0, 1'b1, 64'h1122334455667788,
             1'b1, 1, 1'b1, 1'b0, OK, 64'h1122334455667788, NR, 64'h0);
        idle(64'hDEAD);

        // Out-of-range DMA write, then in-range DMA write
        step(1'b1, 1'b0, RD, 32'h0, 1'b1, WR, 32'h0001_0000, 1'b1, 64'hBEEF,
             1'b0, 2, 1'b0, 1'b1, NR, 64'h0, ER, 64'h0);
        step(1'b1, 1'b0, RD, 32'h0, 1'b1, WR, 32'h0000_FFF8, 1'b1, 64'h0,
             1'b1, 2, 1'b0, 1'b1, NR, 64'h0, OK, 64'h0);

        // Alternating owners back to back
        step(1'b1, 1'b1, RD, 32'h200, 1'b0, RD, 32'h0, 1'b1, 64'hA1A1,
             1'b1, 1, 1'b1, 1'b0, OK, 64'hA1A1, NR, 64'h0);
        step(1'b1, 1'b0, RD, 32'h0, 1'b1, RD, 32'h300, 1'b1, 64'hB2B2,
             1'b1, 2, 1'b0, 1'b1, NR, 64'h0, OK, 64'hB2B2);
        step(1'b1, 1'b1, RD, 32'h208, 1'b0, RD, 32'h0, 1'b1, 64'hC3C3,
             1'b1, 1, 1'b1, 1'b0, OK, 64'hC3C3, NR, 64'h0);
        step(1'b1, 1'b0, RD, 32'h0, 1'b1, RD, 32'h0002_0000, 1'b1, 64'hD4D4,
             1'b0, 2, 1'b0, 1'b1, NR, 64'h0, ER, 64'h0);
        step(1'b1, 1'b1, WR, 32'h210, 1'b0, RD, 32'h0, 1'b1, 64'hE5E5,
             1'b1, 1, 1'b1, 1'b0, OK, 64'hE5E5, NR, 64'h0);

        // TCM stall: forwarded but not acked, no response follows
        step(1'b1, 1'b1, RD, 32'h400, 1'b0, RD, 32'h0, 1'b0, 64'hF6F6,
             1'b1, 1, 1'b0, 1'b0, NR, 64'h0, NR, 64'h0);
        idle(64'h77);

        // Both requesting continuously
        for (int i = 0; i < 10; i++) begin
            dw = StarveEn && (i == 4 || i == 9);
            rd = 64'h5000 + 64'(i);
            step(1'b1, 1'b1, RD, 32'h500, 1'b1, RD, 32'h600, 1'b1, rd,
                 1'b1, dw ? 2 : 1, !dw, dw,
                 dw ? NR : OK, dw ? 64'h0 : rd, dw ? OK : NR, dw ? rd : 64'h0);
        end
        idle(64'h88);

        // Counter advances during TCM stalls; a starved DMA keeps the grant until acked
        for (int i = 0; i < 7; i++) begin
            dw = StarveEn && (i == 4 || i == 5);
            tk = (i >= 5);
            rd = 64'h7000 + 64'(i);
            step(1'b1, 1'b1, RD, 32'h700, 1'b1, WR, 32'h708, tk, rd,
                 1'b1, dw ? 2 : 1, !dw && tk, dw && tk,
                 (!dw && tk) ? OK : NR, (!dw && tk) ? rd : 64'h0,
                 (dw && tk) ? OK : NR, (dw && tk) ? rd : 64'h0);
        end
        idle(64'h99);

        // Reset asserted while a core response is pending: response dropped
        step(1'b1, 1'b1, RD, 32'h800, 1'b0, RD, 32'h0, 1'b1, 64'h1234,
             1'b1, 1, 1'b1, 1'b0, NR, 64'h0, NR, 64'h0);
        step(1'b0, 1'b1, RD, 32'h808, 1'b0, RD, 32'h0, 1'b1, 64'h5678,
             1'b0, 0, 1'b0, 1'b0, NR, 64'h0, NR, 64'h0);
        idle(64'h9ABC);
        step(1'b1, 1'b1, RD, 32'h810, 1'b0, RD, 32'h0, 1'b1, 64'hCAFE,
             1'b1, 1, 1'b1, 1'b0, OK, 64'hCAFE, NR, 64'h0);
        idle(64'h0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(ack_q.size() + rsp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
